// File: rtl/oracle_event_tracker.sv
// Instruction lifecycle tracker between core trace taps and the oracle.
// Checks per-id event order and serialises events into one stream.
module oracle_event_tracker #(
    parameter int NB_ID = 16,
    parameter int DEPTH = 8,
    parameter int XLEN  = 64,
    localparam int ID_W = $clog2(NB_ID)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            dec_valid_i,
    input  logic [ID_W-1:0] dec_id_i,
    input  logic [XLEN-1:0] dec_pc_i,
    input  logic [31:0]     dec_inst_i,
    input  logic            iss_valid_i,
    input  logic [ID_W-1:0] iss_id_i,
    input  logic [XLEN-1:0] iss_rs1_i,
    input  logic [XLEN-1:0] iss_rs2_i,
    input  logic            wb_valid_i,
    input  logic [ID_W-1:0] wb_id_i,
    input  logic [XLEN-1:0] wb_rd_i,
    input  logic            cmt_valid_i,
    input  logic [ID_W-1:0] cmt_id_i,
    output logic            ev_valid_o,
    input  logic            ev_ready_i,
    output logic [1:0]      ev_type_o,
    output logic [ID_W-1:0] ev_id_o,
    output logic [XLEN-1:0] ev_pc_o,
    output logic [XLEN-1:0] ev_data0_o,
    output logic [XLEN-1:0] ev_data1_o,
    output logic            err_o,
    output logic [2:0]      err_code_o,
    output logic [ID_W-1:0] err_id_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_FREE,
        S_DEC,
        S_ISS,
        S_WB
    } id_state_e;

    typedef struct packed {
        logic [1:0]      typ;
        logic [ID_W-1:0] id;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] d0;
        logic [XLEN-1:0] d1;
    } ev_t;

    id_state_e       st_q  [NB_ID];
    logic [XLEN-1:0] pc_q  [NB_ID];
    ev_t             mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            err_q, err_d;
    logic [2:0]      code_q, code_d;
    logic [ID_W-1:0] eid_q, eid_d;

    logic [3:0]       ok;
    logic [3:0]       push;
    ev_t              ev   [4];
    logic [PTR_W-1:0] slot [4];
    logic [CNT_W-1:0] room;
    logic [CNT_W-1:0] n_push;
    logic             ovf;
    logic             pop;
    logic [2:0]       cand;
    logic [ID_W-1:0]  cand_id;
    ev_t              head;

    // Legality of each tap against the state held at the start of the cycle
    always_comb begin
        ok    = '0;
        ok[0] = dec_valid_i && (st_q[dec_id_i] == S_FREE);
        ok[1] = iss_valid_i && (st_q[iss_id_i] == S_DEC);
        ok[2] = wb_valid_i  && (st_q[wb_id_i]  == S_ISS);
        ok[3] = cmt_valid_i && (st_q[cmt_id_i] == S_WB);
    end

    // Event payloads; later stages reuse the PC captured at decode
    always_comb begin
        ev[0] = '{typ: 2'd0, id: dec_id_i, pc: dec_pc_i,
                  d0: XLEN'(dec_inst_i), d1: '0};
        ev[1] = '{typ: 2'd1, id: iss_id_i, pc: pc_q[iss_id_i],
                  d0: iss_rs1_i, d1: iss_rs2_i};
        ev[2] = '{typ: 2'd2, id: wb_id_i, pc: pc_q[wb_id_i],
                  d0: wb_rd_i, d1: '0};
        ev[3] = '{typ: 2'd3, id: cmt_id_i, pc: pc_q[cmt_id_i],
                  d0: '0, d1: '0};
    end

    // Slot allocation in DEC, ISS, WB, CMT order; room excludes same-cycle pop
    always_comb begin
        room   = CNT_W'(DEPTH) - cnt_q;
        n_push = '0;
        ovf    = 1'b0;
        push   = '0;
        for (int i = 0; i < 4; i++) begin
            slot[i] = n_push[PTR_W-1:0];
            if (ok[i]) begin
                if (n_push < room) begin
                    push[i] = 1'b1;
                    n_push  = n_push + CNT_W'(1);
                end else begin
                    ovf = 1'b1;
                end
            end
        end
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        pop      = (cnt_q != '0) && ev_ready_i;
        cnt_d    = cnt_q + n_push - CNT_W'(pop);
        wr_ptr_d = wr_ptr_q + n_push[PTR_W-1:0];
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    // First-error capture; lowest code wins within a cycle
    always_comb begin
        err_d   = err_q;
        code_d  = code_q;
        eid_d   = eid_q;
        cand    = 3'd0;
        cand_id = '0;
        if (dec_valid_i && !ok[0]) begin
            cand    = 3'd1;
            cand_id = dec_id_i;
        end else if (iss_valid_i && !ok[1]) begin
            cand    = 3'd2;
            cand_id = iss_id_i;
        end else if (wb_valid_i && !ok[2]) begin
            cand    = 3'd3;
            cand_id = wb_id_i;
        end else if (cmt_valid_i && !ok[3]) begin
            cand    = 3'd4;
            cand_id = cmt_id_i;
        end else if (ovf) begin
            cand    = 3'd5;
            cand_id = '0;
        end
        if (!err_q && (cand != 3'd0)) begin
            err_d  = 1'b1;
            code_d = cand;
            eid_d  = cand_id;
        end
    end

    // Scoreboard, FIFO control and error registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NB_ID; i++) begin
                st_q[i] <= S_FREE;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            code_q   <= '0;
            eid_q    <= '0;
        end else begin
            if (ok[0]) st_q[dec_id_i] <= S_DEC;
            if (ok[1]) st_q[iss_id_i] <= S_ISS;
            if (ok[2]) st_q[wb_id_i]  <= S_WB;
            if (ok[3]) st_q[cmt_id_i] <= S_FREE;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            code_q   <= code_d;
            eid_q    <= eid_d;
        end
    end

    // Payload storage: decode PCs and queued events need no reset
    always_ff @(posedge clk_i) begin
        if (ok[0]) pc_q[dec_id_i] <= dec_pc_i;
        for (int i = 0; i < 4; i++) begin
            if (push[i]) mem_q[wr_ptr_q + slot[i]] <= ev[i];
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign ev_valid_o = (cnt_q != '0);
    assign ev_type_o  = ev_valid_o ? head.typ : '0;
    assign ev_id_o    = ev_valid_o ? head.id  : '0;
    assign ev_pc_o    = ev_valid_o ? head.pc  : '0;
    assign ev_data0_o = ev_valid_o ? head.d0  : '0;
    assign ev_data1_o = ev_valid_o ? head.d1  : '0;
    assign err_o      = err_q;
    assign err_code_o = code_q;
    assign err_id_o   = eid_q;

endmodule
